// File: rtl/ifu_fetch.sv
// F-stage fetch unit: owns F_PC, issues one instruction-memory request at a time
// and loads each returned word into the F/D register, buffering it while D is stalled.
`timescale 1ns/1ps

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_nextPC,
  input  logic        D_stall,
  output logic        im_req_valid,
  output logic [31:0] im_req_addr,
  input  logic        im_req_ready,
  input  logic        im_resp_valid,
  input  logic [31:0] im_resp_data,
  output logic [31:0] F_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_advance,
  output logic        F_addr_err
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t      state;
  logic [31:0] hold_buf;
  logic [31:0] deliver_word;
  logic        next_pc_bad;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    D_advance    = 1'b0;
    deliver_word = im_resp_data;
    case (state)
      ST_WAIT: D_advance = im_resp_valid && !D_stall;
      ST_HOLD: begin
        D_advance    = !D_stall;
        deliver_word = hold_buf;
      end
      default: ;
    endcase
  end

  assign next_pc_bad  = (F_nextPC[1:0] != 2'b00) || (F_nextPC < PC_LO) || (F_nextPC > PC_HI);
  assign im_req_valid = (state == ST_REQ);
  assign im_req_addr  = F_PC;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_REQ;
      F_PC       <= RESET_PC;
      D_instr    <= '0;
      D_PC       <= '0;
      D_valid    <= 1'b0;
      hold_buf   <= '0;
      F_addr_err <= 1'b0;
    end else begin
      case (state)
        ST_REQ:  if (im_req_ready) state <= ST_WAIT;
        // A response with D stalled is parked, never dropped.
        ST_WAIT: if (im_resp_valid) begin
          if (D_stall) begin
            hold_buf <= im_resp_data;
            state    <= ST_HOLD;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_HOLD: if (!D_stall) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase

      if (D_advance) begin
        D_instr <= deliver_word;
        D_PC    <= F_PC;
        D_valid <= 1'b1;
        F_PC    <= {F_nextPC[31:2], 2'b00};
        if (next_pc_bad) F_addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a memory model issues responses, a reference
// model predicts the delivered (PC, word) stream, and a monitor compares it.
`timescale 1ns/1ps

module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6FFF;

  typedef enum int {M_LINEAR, M_BRANCH, M_HASH, M_TOP, M_ERR_HI, M_ERR_LOW, M_ERR_MIS} mode_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] F_nextPC;
  logic        D_stall = 1'b0;
  logic        im_req_valid;
  logic [31:0] im_req_addr;
  logic        im_req_ready = 1'b0;
  logic        im_resp_valid = 1'b0;
  logic [31:0] im_resp_data = '0;
  logic [31:0] F_PC;
  logic [31:0] D_instr;
  logic [31:0] D_PC;
  logic        D_valid;
  logic        D_advance;
  logic        F_addr_err;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_LO(PC_LO), .PC_HI(PC_HI)) dut (
    .clk          (clk),
    .reset        (reset),
    .F_nextPC     (F_nextPC),
    .D_stall      (D_stall),
    .im_req_valid (im_req_valid),
    .im_req_addr  (im_req_addr),
    .im_req_ready (im_req_ready),
    .im_resp_valid(im_resp_valid),
    .im_resp_data (im_resp_data),
    .F_PC         (F_PC),
    .D_instr      (D_instr),
    .D_PC         (D_PC),
    .D_valid      (D_valid),
    .D_advance    (D_advance),
    .F_addr_err   (F_addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: two fixed words at the reset vector, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h1111_1111;
    if (a == 32'h0000_3004) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Stand-in for the next-PC logic; each mode is a small "program".
  function automatic logic [31:0] next_of(input logic [31:0] pc, input mode_t m);
    case (m)
      M_BRANCH:  return (pc == 32'h0000_3008) ? 32'h0000_3100 : pc + 32'd4;
      M_HASH:    return (pc[4:2] == 3'd5) ? 32'h0000_3000 + {20'd0, pc[11:2] ^ 10'h2A5, 2'b00}
                                          : pc + 32'd4;
      M_TOP:     return (pc == 32'h0000_6FFC) ? 32'h0000_3000 : 32'h0000_6FFC;
      M_ERR_HI:  return 32'h0000_7000;
      M_ERR_LOW: return 32'h0000_2FFC;
      M_ERR_MIS: return 32'h0000_3102;
      default:   return pc + 32'd4;
    endcase
  endfunction

  function automatic logic pc_bad(input logic [31:0] v);
    return (v[1:0] != 2'b00) || (v < PC_LO) || (v > PC_HI);
  endfunction

  mode_t mode = M_LINEAR;
  assign F_nextPC = next_of(F_PC, mode);

  // Knobs set by the main sequence, read by the memory/driver process.
  int ready_pct = 0;
  int stall_pct = 0;
  int lat_min = 1;
  int lat_max = 1;
  int stall_on_resp = 0;
  bit ghost_en = 1'b0;
  bit tput_chk = 1'b0;

  // Reference model and scoreboard (owned by the driver, popped by the monitor).
  fetch_t      q[$];
  fetch_t      f_new;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] np;
  logic        model_err = 1'b0;
  logic        avail = 1'b0;
  logic [31:0] pend_addr = '0;
  int          resp_due = 0;
  int          stall_cnt = 0;
  int          ready_block = 0;
  int          ghost_cnt = 0;
  logic        acc_q = 1'b0;
  logic        del_q = 1'b0;

  // Memory + stimulus driver.
  initial begin
    forever begin
      @(negedge clk);
      acc_q = im_req_valid && im_req_ready && !reset;
      del_q = avail && !D_stall && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        q.delete();
        model_pc      = RESET_PC;
        model_err     = 1'b0;
        avail         = 1'b0;
        resp_due      = 0;
        stall_cnt     = 0;
        ready_block   = 6;
        ghost_cnt     = ghost_en ? 2 : 0;
        im_resp_valid = 1'b0;
        im_req_ready  = 1'b0;
        D_stall       = 1'b0;
      end else begin
        if (acc_q) begin
          f_new.pc    = model_pc;
          f_new.instr = mem_word(model_pc);
          np          = next_of(model_pc, mode);
          model_err   = model_err | pc_bad(np);
          f_new.err   = model_err;
          model_pc    = {np[31:2], 2'b00};
          q.push_back(f_new);
          pend_addr   = f_new.pc;
          resp_due    = int'($urandom_range(lat_max, lat_min));
        end
        if (del_q) avail = 1'b0;
        im_resp_valid = 1'b0;
        im_resp_data  = $urandom;
        if (resp_due > 0) begin
          resp_due--;
          if (resp_due == 0) begin
            im_resp_valid = 1'b1;
            im_resp_data  = mem_word(pend_addr);
            avail         = 1'b1;
            stall_cnt     = stall_on_resp;
          end
        end else if (ghost_cnt > 0) begin
          ghost_cnt--;
          if (ghost_cnt == 0) begin
            im_resp_valid = 1'b1;
            im_resp_data  = 32'hDEAD_BEEF;
          end
        end
        if (stall_cnt > 0) begin
          D_stall = 1'b1;
          stall_cnt--;
        end else begin
          D_stall = int'($urandom_range(99, 0)) < stall_pct;
        end
        if (ready_block > 0) begin
          im_req_ready = 1'b0;
          ready_block--;
        end else begin
          im_req_ready = int'($urandom_range(99, 0)) < ready_pct;
        end
      end
    end
  end

  // Monitor: per-cycle protocol checks at negedge, delivery checks just after posedge.
  int          ndel = 0;
  int          cyc = 0;
  int          last_del_cyc = -1;
  logic        exp_del;
  logic [31:0] exp_fpc;
  fetch_t      got;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = '0;
  logic        last_valid = 1'b0;
  logic        last_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_pc    = '0;
        last_instr = '0;
        last_valid = 1'b0;
        last_err   = 1'b0;
        continue;
      end
      exp_del = avail && !D_stall;
      exp_fpc = (q.size() != 0) ? q[0].pc : model_pc;
      check("d_advance",    32'(D_advance),    32'(exp_del));
      check("req_valid",    32'(im_req_valid), 32'(q.size() == 0));
      check("f_pc",         F_PC,              exp_fpc);
      check("req_addr",     im_req_addr,       exp_fpc);
      check("addr_err",     32'(F_addr_err),   32'(last_err));
      @(posedge clk);
      #1;
      if (reset) continue;
      cyc++;
      if (!tput_chk) last_del_cyc = -1;
      if (exp_del && q.size() != 0) begin
        got = q.pop_front();
        check("d_pc",    D_PC,          got.pc);
        check("d_instr", D_instr,       got.instr);
        check("d_valid", 32'(D_valid),  32'd1);
        last_pc    = got.pc;
        last_instr = got.instr;
        last_valid = 1'b1;
        last_err   = got.err;
        ndel++;
        if (tput_chk && last_del_cyc >= 0) check("throughput_gap", 32'(cyc - last_del_cyc), 32'd2);
        last_del_cyc = cyc;
      end else begin
        check("d_pc_hold",    D_PC,         last_pc);
        check("d_instr_hold", D_instr,      last_instr);
        check("d_valid_hold", 32'(D_valid), 32'(last_valid));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_f_pc",      F_PC,              RESET_PC);
    check("rst_d_valid",   32'(D_valid),      32'd0);
    check("rst_d_pc",      D_PC,              32'd0);
    check("rst_d_instr",   D_instr,           32'd0);
    check("rst_addr_err",  32'(F_addr_err),   32'd0);
    check("rst_req_valid", 32'(im_req_valid), 32'd1);
    check("rst_d_advance", 32'(D_advance),    32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_deliveries(input int n);
    int target;
    int budget;
    target = ndel + n;
    budget = n * 60;
    while (ndel < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("delivery_budget", 32'(ndel >= target), 32'd1);
  endtask

  task automatic drain();
    int budget;
    ready_pct = 0;
    stall_pct = 0;
    budget    = 200;
    repeat (2) @(posedge clk);
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain_done", 32'(q.size() == 0), 32'd1);
  endtask

  initial begin
    int budget;
    do_reset();

    // Back-to-back fetch at full rate: one delivery every 2 cycles.
    mode = M_LINEAR; lat_min = 1; lat_max = 1; ready_pct = 100; stall_pct = 0;
    tput_chk = 1'b1;
    wait_deliveries(6);
    tput_chk = 1'b0;
    drain();

    // Response lands while D is stalled for 3 cycles.
    stall_on_resp = 3; lat_min = 1; lat_max = 2; ready_pct = 100;
    wait_deliveries(4);
    stall_on_resp = 0;
    drain();

    // Request held with ready low for 4 cycles.
    repeat (4) @(posedge clk);
    ready_pct = 100;
    wait_deliveries(3);
    drain();

    // Branch redirect after the delay slot at 0x3008.
    do_reset();
    mode = M_BRANCH; ready_pct = 100; lat_min = 1; lat_max = 2;
    wait_deliveries(5);
    drain();

    // Randomized traffic.
    mode = M_HASH; ready_pct = 60; stall_pct = 30; lat_min = 1; lat_max = 4;
    wait_deliveries(60);
    drain();

    // Upper legal boundary, then just past it.
    mode = M_TOP; ready_pct = 100; stall_pct = 20; lat_min = 1; lat_max = 2;
    wait_deliveries(4);
    drain();
    mode = M_ERR_HI; ready_pct = 100;
    wait_deliveries(2);
    drain();

    // Reset while a response is outstanding; a stray response follows release.
    mode = M_LINEAR; lat_min = 4; lat_max = 4; ready_pct = 100;
    budget = 50;
    while (q.size() == 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    check("wait_entered", 32'(q.size() != 0), 32'd1);
    ghost_en = 1'b1;
    do_reset();
    ghost_en = 1'b0;
    lat_min = 1; lat_max = 3; ready_pct = 100;
    wait_deliveries(3);
    drain();

    // Misaligned target: aligned load and sticky error.
    mode = M_ERR_MIS; ready_pct = 100;
    wait_deliveries(2);
    drain();
    mode = M_LINEAR; ready_pct = 100;
    wait_deliveries(2);
    drain();

    // Just below the lower boundary.
    do_reset();
    mode = M_ERR_LOW; ready_pct = 100; stall_pct = 25;
    wait_deliveries(2);
    drain();
    mode = M_LINEAR; ready_pct = 100;
    wait_deliveries(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
